// File: rtl/uart8_pkg.sv
// Shared types for the UART byte-transmit FIFO: drain FSM states and the
// width of the optional drop counter (UART8_TX_FIFO_STATS_EN).
package uart8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } txState_t;

    localparam int DROP_CNT_W = 16;

    function automatic logic [DROP_CNT_W-1:0] satInc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart8_tx_fifo_if.sv
// Transmitter-side handshake between the FIFO drain logic (master) and a
// byte-wide UART transmitter (slave).
interface uart8_tx_fifo_if;

    logic       txStart;
    logic [7:0] txData;
    logic       txBusy;

    modport master (output txStart, output txData, input txBusy);
    modport slave  (input txStart, input txData, output txBusy);

endinterface

// File: rtl/uart8_fifo_mem.sv
// DEPTH x 8 byte store: one write port, one registered read port.
// The read register is reset so the transmitter sees 0x00 after reset.
module uart8_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [7:0]    wrData,
    input  logic          rdEn,
    input  logic [AW-1:0] rdAddr,
    output logic [7:0]    rdData
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Read-first: a pop of the slot being overwritten by a same-cycle push
    // (full FIFO) returns the old head byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/uart8_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter through a start/busy handshake.
// Define UART8_TX_FIFO_STATS_EN to add the saturating dropCount output.
module uart8_tx_fifo
    import uart8_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   wrEn,
    input  logic [7:0]             wrData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   txErr,
    input  logic                   clrErr,
    uart8_tx_fifo_if.master        txIf
`ifdef UART8_TX_FIFO_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0]  dropCount
`endif
);

    localparam int AW          = $clog2(DEPTH);
    localparam int LW          = AW + 1;
    localparam int TW          = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int SYNC_STAGES = 2;

    txState_t          stateReg, stateNext;
    logic [TW-1:0]     cntReg, cntNext;
    logic [AW-1:0]     wrPtrReg, rdPtrReg;
    logic [LW-1:0]     levelReg;
    logic              overflowReg, txErrReg;
    logic [SYNC_STAGES-1:0] busySyncReg;

    logic busy, pop, push, drop, timeoutHit;

    // txBusy may come from a slower clock domain. The synchronizer resets to
    // "busy" so a transmitter still running across our reset is waited out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busySyncReg <= '1;
        end else begin
            busySyncReg <= {busySyncReg[SYNC_STAGES-2:0], txIf.txBusy};
        end
    end
    assign busy = busySyncReg[SYNC_STAGES-1];

    assign full  = (levelReg == LW'(DEPTH));
    assign empty = (levelReg == '0);
    assign level = levelReg;

    assign pop  = (stateReg == IDLE) && en && !empty && !busy;
    assign push = wrEn && (!full || pop);
    assign drop = wrEn && full && !pop;

    uart8_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (push),
        .wrAddr (wrPtrReg),
        .wrData (wrData),
        .rdEn   (pop),
        .rdAddr (rdPtrReg),
        .rdData (txIf.txData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            levelReg <= '0;
        end else begin
            if (push) wrPtrReg <= wrPtrReg + AW'(1);
            if (pop)  rdPtrReg <= rdPtrReg + AW'(1);
            if (push && !pop) begin
                levelReg <= levelReg + LW'(1);
            end else if (pop && !push) begin
                levelReg <= levelReg - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        cntNext    = cntReg;
        timeoutHit = 1'b0;
        unique case (stateReg)
            IDLE: begin
                if (pop) begin
                    stateNext = START;
                    cntNext   = '0;
                end
            end
            START: begin
                if (busy) begin
                    stateNext = WAIT;
                end else if (cntReg == TW'(START_TIMEOUT - 1)) begin
                    // Transmitter never answered: give up on this byte.
                    stateNext  = IDLE;
                    timeoutHit = 1'b1;
                end else begin
                    cntNext = cntReg + TW'(1);
                end
            end
            WAIT: begin
                if (!busy) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign txIf.txStart = (stateReg == START);

    // Sticky flags: a new event in the same cycle as clrErr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflowReg <= 1'b0;
            txErrReg    <= 1'b0;
        end else begin
            if (drop)        overflowReg <= 1'b1;
            else if (clrErr) overflowReg <= 1'b0;
            if (timeoutHit)  txErrReg <= 1'b1;
            else if (clrErr) txErrReg <= 1'b0;
        end
    end

    assign overflow = overflowReg;
    assign txErr    = txErrReg;

`ifdef UART8_TX_FIFO_STATS_EN
    logic [DROP_CNT_W-1:0] dropCntReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropCntReg <= '0;
        end else if (drop) begin
            dropCntReg <= clrErr ? DROP_CNT_W'(1) : satInc(dropCntReg);
        end else if (clrErr) begin
            dropCntReg <= '0;
        end
    end

    assign dropCount = dropCntReg;
`endif

endmodule

// File: tb/tb_uart8_tx_fifo.sv
// Scoreboard bench for uart8_tx_fifo; dropCount checks are compiled in
// when UART8_TX_FIFO_STATS_EN is defined.
module tb_uart8_tx_fifo;
    import uart8_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, wrEn, clrErr;
    logic [7:0]    wrData;
    logic          full, empty, overflow, txErr;
    logic [LW-1:0] level;

    logic          enS, wrEnS;
    logic [7:0]    wrDataS;
    logic          fullS, emptyS, overflowS, txErrS;
    logic [LW-1:0] levelS;

`ifdef UART8_TX_FIFO_STATS_EN
    logic [DROP_CNT_W-1:0] dropCount, dropCountS;
`endif

    uart8_tx_fifo_if txIf ();
    uart8_tx_fifo_if slowIf ();

    uart8_tx_fifo #(.DEPTH(DEPTH), .START_TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .en(en), .wrEn(wrEn), .wrData(wrData),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .txErr(txErr), .clrErr(clrErr), .txIf(txIf)
`ifdef UART8_TX_FIFO_STATS_EN
        , .dropCount(dropCount)
`endif
    );

    uart8_tx_fifo #(.DEPTH(DEPTH)) dutSlow (
        .clk(clk), .rst(rst), .en(enS), .wrEn(wrEnS), .wrData(wrDataS),
        .full(fullS), .empty(emptyS), .level(levelS), .overflow(overflowS),
        .txErr(txErrS), .clrErr(clrErr), .txIf(slowIf)
`ifdef UART8_TX_FIFO_STATS_EN
        , .dropCount(dropCountS)
`endif
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expQ[$];
    int         startCount = 0;
    logic       prevStart = 1'b0;
    logic [7:0] heldData = 8'h00;
    bit         modelOn = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic boundFail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitor: each txStart rising edge pops one expected byte.
    always @(negedge clk) begin
        if (rst) begin
            prevStart = 1'b0;
        end else begin
            if (txIf.txStart && !prevStart) begin
                startCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got txData 0x%0h, want no start", txIf.txData);
                end else begin
                    check("txData_seq", {24'h0, txIf.txData}, {24'h0, expQ.pop_front()});
                end
                heldData = txIf.txData;
            end else if (txIf.txStart) begin
                check("txData_hold", {24'h0, txIf.txData}, {24'h0, heldData});
            end
            prevStart = txIf.txStart;
        end
    end

    // Transmitter model: busy for 20 cycles after each start it sees.
    initial begin
        txIf.txBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (modelOn && !rst && txIf.txStart && !txIf.txBusy) begin
                txIf.txBusy = 1'b1;
                repeat (20) @(negedge clk);
                txIf.txBusy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [7:0] b);
        wrEn   = 1'b1;
        wrData = b;
        @(negedge clk);
        wrEn   = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (!(expQ.size() == 0 && empty && !txIf.txStart && !txIf.txBusy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(expQ.size() == 0 && empty && !txIf.txStart && !txIf.txBusy)) boundFail(name);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int s0, n, hi, lo, bad;
        rst = 1'b1; en = 1'b0; wrEn = 1'b0; wrData = 8'h00; clrErr = 1'b0;
        enS = 1'b0; wrEnS = 1'b0; wrDataS = 8'h00; slowIf.txBusy = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_level",    32'(level), 0);
        check("rst_empty",    32'(empty), 1);
        check("rst_full",     32'(full), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_txErr",    32'(txErr), 0);
        check("rst_txStart",  32'(txIf.txStart), 0);
        check("rst_txData",   32'(txIf.txData), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Three bytes through the 20-cycle transmitter model.
        s0 = startCount;
        en = 1'b1;
        expQ.push_back(8'h41); expQ.push_back(8'h42); expQ.push_back(8'h43);
        wr(8'h41); wr(8'h42); wr(8'h43);
        waitDrain("seq3_drain", 500);
        check("seq3_starts", 32'(startCount - s0), 3);
        check("seq3_level",  32'(level), 0);

        // Fill with en=0, 17th write dropped.
        en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expQ.push_back(8'(i));
            wr(8'(i));
        end
        check("fill_full",     32'(full), 1);
        check("fill_level",    32'(level), 16);
        check("fill_overflow", 32'(overflow), 1);
`ifdef UART8_TX_FIFO_STATS_EN
        check("fill_dropCount", 32'(dropCount), 1);
`endif
        clrErr = 1'b1;
        @(negedge clk);
        clrErr = 1'b0;
        check("clr_overflow", 32'(overflow), 0);
`ifdef UART8_TX_FIFO_STATS_EN
        check("clr_dropCount", 32'(dropCount), 0);
`endif

        // Full FIFO: push and pop in the same cycle.
        expQ.push_back(8'hA0);
        en = 1'b1; wrEn = 1'b1; wrData = 8'hA0;
        @(negedge clk);
        wrEn = 1'b0;
        check("pushpop_level",    32'(level), 16);
        check("pushpop_full",     32'(full), 1);
        check("pushpop_overflow", 32'(overflow), 0);
        waitDrain("drain17", 2000);
        check("drain17_level", 32'(level), 0);
        check("drain17_empty", 32'(empty), 1);

        // Start timeout with txBusy held low.
        modelOn = 1'b0;
        expQ.push_back(8'h55);
        wr(8'h55);
        n = 0;
        while (!txIf.txStart && n < 20) begin @(negedge clk); n++; end
        if (!txIf.txStart) boundFail("timeout_start");
        hi = 0;
        while (txIf.txStart && hi < 1000) begin hi++; @(negedge clk); end
        check("timeout_len",     32'(hi), 100);
        check("timeout_txErr",   32'(txErr), 1);
        check("timeout_empty",   32'(empty), 1);
        check("timeout_txStart", 32'(txIf.txStart), 0);
        clrErr = 1'b1;
        @(negedge clk);
        clrErr = 1'b0;
        check("clr_txErr", 32'(txErr), 0);
        modelOn = 1'b1;
        repeat (3) @(negedge clk);

        // Reset while in WAIT with five bytes still stored.
        en = 1'b0;
        expQ.push_back(8'h61);
        for (int i = 0; i < 6; i++) wr(8'h61 + 8'(i));
        en = 1'b1;
        n = 0;
        while (!(txIf.txBusy && !txIf.txStart) && n < 100) begin @(negedge clk); n++; end
        if (!(txIf.txBusy && !txIf.txStart)) boundFail("wait_reach");
        check("wait_level", 32'(level), 5);
        en = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_level",   32'(level), 0);
        check("midrst_empty",   32'(empty), 1);
        check("midrst_txStart", 32'(txIf.txStart), 0);
        @(negedge clk);
        rst = 1'b0;
        s0 = startCount;
        en = 1'b1;
        expQ.push_back(8'h77);
        wr(8'h77);
        bad = 0; n = 0;
        while (txIf.txBusy && n < 100) begin
            if (txIf.txStart) bad++;
            @(negedge clk);
            n++;
        end
        check("postrst_start_while_busy", 32'(bad), 0);
        waitDrain("postrst_drain", 300);
        check("postrst_starts", 32'(startCount - s0), 1);

        // Slow transmitter: busy rises 5000 cycles after txStart.
        enS = 1'b1; wrEnS = 1'b1; wrDataS = 8'hC3;
        @(negedge clk);
        wrEnS = 1'b0;
        n = 0;
        while (!slowIf.txStart && n < 20) begin @(negedge clk); n++; end
        if (!slowIf.txStart) boundFail("slow_start");
        lo = 0;
        repeat (5000) begin
            if (!slowIf.txStart) lo++;
            @(negedge clk);
        end
        check("slow_held", 32'(lo), 0);
        slowIf.txBusy = 1'b1;
        n = 0;
        while (slowIf.txStart && n < 20) begin @(negedge clk); n++; end
        check("slow_txStart_fall", 32'(slowIf.txStart), 0);
        check("slow_txErr",  32'(txErrS), 0);
        check("slow_txData", 32'(slowIf.txData), 32'h0C3);
        repeat (20) @(negedge clk);
        slowIf.txBusy = 1'b0;
        repeat (5) @(negedge clk);
        check("slow_level",   32'(levelS), 0);
        check("slow_empty",   32'(emptyS), 1);
        check("slow_txErr_end", 32'(txErrS), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
